// File: rtl/seg_write_sequencer.sv
// seg_write_sequencer: Avalon-MM master feeding the 7-segment display slave.
// One write per dirty digit, optional leading-zero blanking and skipping.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   value_i             packed hex value, nibble k -> digit k
//   value_valid_i       value_i / blank_lz_i valid
//   value_ready_o       sequencer idle and able to accept
//   blank_lz_i          blank leading zeros of this value
//   avm_address_o       digit index being written
//   avm_write_o         write strobe
//   avm_writedata_o     digit code
//   avm_waitrequest_i   slave stall
//   busy_o              sequence in progress
//   done_o              one-cycle pulse after last write
module seg_write_sequencer #(
  parameter int         NUM_SEGMENT    = 6,
  parameter bit         SKIP_UNCHANGED = 1'b1,
  parameter logic [7:0] BLANK_CODE     = 8'h10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_SEGMENT*4-1:0] value_i,
  input  logic                     value_valid_i,
  output logic                     value_ready_o,
  input  logic                     blank_lz_i,
  output logic [2:0]               avm_address_o,
  output logic                     avm_write_o,
  output logic [7:0]               avm_writedata_o,
  input  logic                     avm_waitrequest_i,
  output logic                     busy_o,
  output logic                     done_o
);

  localparam int N  = NUM_SEGMENT;
  localparam int CW = N * 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q;
  logic          ready_q;
  logic          write_q;
  logic          done_q;
  logic          shadow_vld_q;
  logic [2:0]    addr_q;
  logic [7:0]    data_q;
  logic [CW-1:0] code_q;
  logic [CW-1:0] shadow_q;
  logic [N-1:0]  dirty_q;

  logic          zeros;
  logic [CW-1:0] new_code;
  logic [N-1:0]  new_dirty;
  logic [N-1:0]  done_bit;
  logic [N-1:0]  dirty_rem;
  logic [2:0]    pick_new;
  logic [2:0]    pick_rem;
  logic          accept;
  logic          xfer_done;

  function automatic logic [2:0] lowest(
    input logic [N-1:0] m
  );
    logic [2:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (m[k]) idx = 3'(k);
    end
    return idx;
  endfunction

  // Walk from the top digit down so "all higher
  // nibbles zero" is known at each digit.
  always_comb begin
    zeros     = 1'b1;
    new_code  = '0;
    new_dirty = '0;
    for (int k = N - 1; k >= 0; k--) begin
      zeros = zeros & (value_i[4*k +: 4] == 4'h0);
      if (blank_lz_i && (k != 0) && zeros) begin
        new_code[8*k +: 8] = BLANK_CODE;
      end else begin
        new_code[8*k +: 8] = {4'h0, value_i[4*k +: 4]};
      end
      new_dirty[k] = !SKIP_UNCHANGED
                  || !shadow_vld_q
                  || (new_code[8*k +: 8]
                      != shadow_q[8*k +: 8]);
    end
  end

  assign done_bit  = {{(N-1){1'b0}}, 1'b1} << addr_q;
  assign dirty_rem = dirty_q & ~done_bit;
  assign pick_new  = lowest(new_dirty);
  assign pick_rem  = lowest(dirty_rem);
  assign accept    = ready_q & value_valid_i;
  assign xfer_done = write_q & ~avm_waitrequest_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      write_q      <= 1'b0;
      done_q       <= 1'b0;
      shadow_vld_q <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      code_q       <= '0;
      shadow_q     <= '0;
      dirty_q      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            code_q  <= new_code;
            dirty_q <= new_dirty;
            if (|new_dirty) begin
              state_q <= S_WRITE;
              write_q <= 1'b1;
              addr_q  <= pick_new;
              data_q  <= new_code[8*pick_new +: 8];
            end else begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_WRITE: begin
          // Address/data stay put until the slave
          // releases waitrequest.
          if (xfer_done) begin
            dirty_q <= dirty_rem;
            shadow_q[8*addr_q +: 8] <= data_q;
            if (|dirty_rem) begin
              addr_q <= pick_rem;
              data_q <= code_q[8*pick_rem +: 8];
            end else begin
              write_q <= 1'b0;
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          shadow_vld_q <= 1'b1;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          write_q <= 1'b0;
          ready_q <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign value_ready_o   = ready_q;
  assign avm_write_o     = write_q;
  assign avm_address_o   = addr_q;
  assign avm_writedata_o = data_q;
  assign busy_o          = (state_q != S_IDLE);
  assign done_o          = done_q;

endmodule

// File: tb/tb_seg_write_sequencer.sv
// tb_seg_write_sequencer: directed bench for seg_write_sequencer.
// Expected writes are queued at stimulus time and popped on completion.
module tb_seg_write_sequencer;

  localparam int N = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N*4-1:0] value_i = '0;
  logic          value_valid_i = 1'b0;
  logic          value_ready_o;
  logic          blank_lz_i = 1'b0;
  logic [2:0]    avm_address_o;
  logic          avm_write_o;
  logic [7:0]    avm_writedata_o;
  logic          avm_waitrequest_i = 1'b0;
  logic          busy_o;
  logic          done_o;

  seg_write_sequencer #(
    .NUM_SEGMENT   (N),
    .SKIP_UNCHANGED(1'b1),
    .BLANK_CODE    (8'h10)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .value_i          (value_i),
    .value_valid_i    (value_valid_i),
    .value_ready_o    (value_ready_o),
    .blank_lz_i       (blank_lz_i),
    .avm_address_o    (avm_address_o),
    .avm_write_o      (avm_write_o),
    .avm_writedata_o  (avm_writedata_o),
    .avm_waitrequest_i(avm_waitrequest_i),
    .busy_o           (busy_o),
    .done_o           (done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        exp_q[$];
  wr_t        e;
  logic [7:0] m_shadow [N];
  bit         m_valid = 1'b0;
  int         checks = 0;
  int         errors = 0;

  logic [2:0] p_addr;
  logic [7:0] p_data;
  bit         p_stall = 1'b0;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // Completion monitor: a write with waitrequest low
  // at the falling edge completes on the next rise.
  always @(negedge clk) begin
    if (!rst_n) begin
      p_stall = 1'b0;
    end else begin
      if (p_stall) begin
        chk("hold_write", {31'b0, avm_write_o}, 1);
        chk("hold_addr", {29'b0, avm_address_o},
            {29'b0, p_addr});
        chk("hold_data", {24'b0, avm_writedata_o},
            {24'b0, p_data});
      end
      p_stall = avm_write_o && avm_waitrequest_i;
      p_addr  = avm_address_o;
      p_data  = avm_writedata_o;
      if (avm_write_o && !avm_waitrequest_i) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write",
              {31'b0, avm_write_o}, 0);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", {29'b0, avm_address_o},
              {29'b0, e.a});
          chk("wr_data", {24'b0, avm_writedata_o},
              {24'b0, e.d});
        end
      end
    end
  end

  task automatic run_seq(
    input logic [N*4-1:0] v,
    input bit             blz,
    input int             s_addr,
    input int             s_cycles,
    input int             r_addr
  );
    logic [7:0] codes [N];
    bit z;
    int w;
    int got;
    int held;
    int left;
    bit did_rst;
    z = 1'b1;
    w = 0;
    got = 0;
    held = 0;
    did_rst = 1'b0;
    left = s_cycles;
    for (int k = N - 1; k >= 0; k--) begin
      z = z && (v[4*k +: 4] == 4'h0);
      if (blz && k != 0 && z) codes[k] = 8'h10;
      else codes[k] = {4'h0, v[4*k +: 4]};
    end
    for (int k = 0; k < N; k++) begin
      if (!m_valid || codes[k] != m_shadow[k]) begin
        exp_q.push_back('{a: 3'(k), d: codes[k]});
        w++;
      end
    end
    for (int i = 0; i < 10 && !value_ready_o; i++)
      @(negedge clk);
    chk("ready_before", {31'b0, value_ready_o}, 1);
    value_i = v;
    blank_lz_i = blz;
    value_valid_i = 1'b1;
    @(posedge clk);
    #1;
    value_valid_i = 1'b0;
    value_i = N*4'($urandom);
    blank_lz_i = 1'($urandom);
    for (int i = 1; i <= 40; i++) begin
      if (i > 1) begin
        @(posedge clk);
        #1;
      end
      if (r_addr >= 0 && avm_write_o
          && avm_address_o == r_addr) begin
        rst_n = 1'b0;
        #1;
        chk("rst_write_drop", {31'b0, avm_write_o}, 0);
        chk("rst_busy", {31'b0, busy_o}, 0);
        chk("rst_ready", {31'b0, value_ready_o}, 0);
        chk("rst_addr", {29'b0, avm_address_o}, 0);
        did_rst = 1'b1;
        break;
      end
      if (s_addr >= 0 && avm_write_o
          && avm_address_o == s_addr && left > 0) begin
        avm_waitrequest_i = 1'b1;
        left--;
      end else begin
        avm_waitrequest_i = 1'b0;
      end
      @(negedge clk);
      if (avm_write_o && avm_address_o == s_addr)
        held++;
      if (done_o) begin
        got = i;
        break;
      end
    end
    if (did_rst) begin
      exp_q.delete();
      m_valid = 1'b0;
      avm_waitrequest_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
    end else begin
      chk("done_cycle", got, w + 1 + s_cycles);
      chk("done_busy", {31'b0, busy_o}, 1);
      chk("done_nowrite", {31'b0, avm_write_o}, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("done_one_cycle", {31'b0, done_o}, 0);
      chk("ready_after", {31'b0, value_ready_o}, 1);
      chk("idle_busy", {31'b0, busy_o}, 0);
      chk("all_writes_seen", exp_q.size(), 0);
      if (s_cycles > 0)
        chk("stall_hold", held, s_cycles + 1);
      for (int k = 0; k < N; k++)
        m_shadow[k] = codes[k];
      m_valid = 1'b1;
    end
  endtask

  initial begin
    #12;
    chk("reset_ready", {31'b0, value_ready_o}, 0);
    chk("reset_write", {31'b0, avm_write_o}, 0);
    chk("reset_addr", {29'b0, avm_address_o}, 0);
    chk("reset_data", {24'b0, avm_writedata_o}, 0);
    chk("reset_busy", {31'b0, busy_o}, 0);
    chk("reset_done", {31'b0, done_o}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_seq(24'h12AB3F, 1'b0, -1, 0, -1);
    run_seq(24'h00000A, 1'b1, -1, 0, -1);
    run_seq(24'h000000, 1'b1, -1, 0, -1);
    run_seq(24'h123456, 1'b0, -1, 0, -1);
    run_seq(24'h123457, 1'b0, -1, 0, -1);
    run_seq(24'h123457, 1'b0, -1, 0, -1);
    run_seq(24'h654321, 1'b0, 2, 3, -1);
    run_seq(24'h123457, 1'b0, -1, 0, 3);
    run_seq(24'h123457, 1'b0, -1, 0, -1);
    run_seq(24'h0000F0, 1'b1, -1, 0, -1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
